// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared RV32I decode constants, encodings, ID/EX bundle and the
//            immediate extender used by the decode stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic              reg_write;
        result_src_e       result_src;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        logic [2:0]        alu_control;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm_ext;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
    } idex_t;

    function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr,
                                                   input imm_src_e    src);
        logic [XLEN-1:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            default: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
        endcase
        return imm;
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file
// Purpose  : 32x32 architectural register file, two async read ports, one
//            write port, x0 hard-wired to zero. Write-through reads when
//            DECODE_WB_BYPASS_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    // A non-zero read address implies a non-zero write address on a match.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
        if (raddr2 != '0) rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
    end
`else
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) rdata1 = regs_q[raddr1];
        if (raddr2 != '0) rdata2 = regs_q[raddr2];
    end
`endif

endmodule

`default_nettype wire

// File: rtl/decode_cycle.sv
// ============================================================================
// Module   : decode_cycle
// Purpose  : RV32I ID stage: main/ALU decode, register read, immediate
//            extension, ID/EX pipeline register. Optional macro
//            DECODE_WB_BYPASS_EN enables write-through register reads.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RDE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    import riscv_pkg::*;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            reg_write;
    result_src_e     result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    imm_src_e        imm_src;
    logic            imm_valid;
    alu_op_e         alu_op;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    idex_t           idex_d;
    idex_t           idex_q;
    idex_t           idex_o;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];

    always_comb begin
        reg_write  = 1'b0;
        result_src = RES_ALU;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        imm_valid  = 1'b1;
        alu_op     = ALUOP_ADD;
        case (opcode)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_SW: begin
                mem_write = 1'b1;
                imm_src   = IMM_S;
                alu_src   = 1'b1;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = ALUOP_FUNC;
            end
            OP_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNC;
            end
            OP_BEQ: begin
                branch  = 1'b1;
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
            default: imm_valid = 1'b0;
        endcase
    end

    // Only R-type (op[5]=1) may subtract; I-ALU funct3=000 is always addi.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:  alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    3'b000:  alu_control = (InstrD[30] & opcode[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:    alu_control = ALU_ADD;
        endcase
    end

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_register_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (InstrD[19:15]),
        .raddr2 (InstrD[24:20]),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .we     (RegWriteW),
        .waddr  (RDW),
        .wdata  (ResultW)
    );

    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = reg_write;
        idex_d.result_src  = result_src;
        idex_d.mem_write   = mem_write;
        idex_d.jump        = jump;
        idex_d.branch      = branch;
        idex_d.alu_src     = alu_src;
        idex_d.alu_control = imm_valid ? alu_control : 3'b000;
        idex_d.rd1         = rd1;
        idex_d.rd2         = rd2;
        idex_d.imm_ext     = imm_valid ? imm_extend(InstrD, imm_src) : '0;
        idex_d.rs1         = InstrD[19:15];
        idex_d.rs2         = InstrD[24:20];
        idex_d.rd          = InstrD[11:7];
        idex_d.pc          = PCD;
        idex_d.pc_plus4    = PCPlus4D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    assign idex_o = rst ? idex_q : '0;

    assign RegWriteE   = idex_o.reg_write;
    assign ResultSrcE  = idex_o.result_src;
    assign MemWriteE   = idex_o.mem_write;
    assign JumpE       = idex_o.jump;
    assign BranchE     = idex_o.branch;
    assign ALUSrcE     = idex_o.alu_src;
    assign ALUControlE = idex_o.alu_control;
    assign RD1E        = idex_o.rd1;
    assign RD2E        = idex_o.rd2;
    assign ImmExtE     = idex_o.imm_ext;
    assign Rs1E        = idex_o.rs1;
    assign Rs2E        = idex_o.rs2;
    assign RDE         = idex_o.rd;
    assign PCE         = idex_o.pc;
    assign PCPlus4E    = idex_o.pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_decode_cycle.sv
// ============================================================================
// Module   : tb_decode_cycle
// Purpose  : Scoreboard bench for decode_cycle; honours DECODE_WB_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  RDW = '0;
    logic [31:0] ResultW = '0;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RDE;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw, jmp, br, as;
        logic [2:0]  ac;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  r1, r2, rd;
        logic [31:0] pc, pc4;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mregs [32];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return mregs[a];
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                   input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e;
        logic [1:0]  aop;
        logic [31:0] immI, immS, immB, immJ;
        immI = {{20{i[31]}}, i[31:20]};
        immS = {{20{i[31]}}, i[31:25], i[11:7]};
        immB = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        immJ = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        e = '0;
        aop = 2'b00;
        case (i[6:0])
            7'b0000011: begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.imm = immI; end
            7'b0100011: begin e.mw = 1; e.as = 1; e.imm = immS; end
            7'b0110011: begin e.rw = 1; aop = 2'b10; e.imm = immI; end
            7'b0010011: begin e.rw = 1; e.as = 1; aop = 2'b10; e.imm = immI; end
            7'b1100011: begin e.br = 1; aop = 2'b01; e.imm = immB; end
            7'b1101111: begin e.rw = 1; e.jmp = 1; e.rs = 2'b10; e.imm = immJ; end
            default:    aop = 2'b11;
        endcase
        case (aop)
            2'b01: e.ac = 3'b001;
            2'b10: case (i[14:12])
                       3'b000:  e.ac = (i[30] && i[5]) ? 3'b001 : 3'b000;
                       3'b010:  e.ac = 3'b101;
                       3'b110:  e.ac = 3'b011;
                       3'b111:  e.ac = 3'b010;
                       default: e.ac = 3'b000;
                   endcase
            default: e.ac = 3'b000;
        endcase
        e.rd1 = mread(i[19:15], we, wa, wd);
        e.rd2 = mread(i[24:20], we, wa, wd);
        e.r1  = i[19:15];
        e.r2  = i[24:20];
        e.rd  = i[11:7];
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".RegWriteE"},   {31'd0, RegWriteE},   {31'd0, e.rw});
        chk({tag, ".ResultSrcE"},  {30'd0, ResultSrcE},  {30'd0, e.rs});
        chk({tag, ".MemWriteE"},   {31'd0, MemWriteE},   {31'd0, e.mw});
        chk({tag, ".JumpE"},       {31'd0, JumpE},       {31'd0, e.jmp});
        chk({tag, ".BranchE"},     {31'd0, BranchE},     {31'd0, e.br});
        chk({tag, ".ALUSrcE"},     {31'd0, ALUSrcE},     {31'd0, e.as});
        chk({tag, ".ALUControlE"}, {29'd0, ALUControlE}, {29'd0, e.ac});
        chk({tag, ".RD1E"},        RD1E,                 e.rd1);
        chk({tag, ".RD2E"},        RD2E,                 e.rd2);
        chk({tag, ".ImmExtE"},     ImmExtE,              e.imm);
        chk({tag, ".Rs1E"},        {27'd0, Rs1E},        {27'd0, e.r1});
        chk({tag, ".Rs2E"},        {27'd0, Rs2E},        {27'd0, e.r2});
        chk({tag, ".RDE"},         {27'd0, RDE},         {27'd0, e.rd});
        chk({tag, ".PCE"},         PCE,                  e.pc);
        chk({tag, ".PCPlus4E"},    PCPlus4E,             e.pc4);
    endtask

    // Drive one ID cycle on the falling edge, score it just after the next rise.
    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
        RegWriteW = we; RDW = wa; ResultW = wd;
        sb_q.push_back(model(instr, pc, we, wa, wd));
        if (we && wa != 5'd0) mregs[wa] = wd;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_all(tag, e);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  ops [7];
        exp_t        zero_e;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ops[6] = 7'b1111111;
        for (int k = 0; k < 32; k++) mregs[k] = '0;
        zero_e = '0;

        // Held in reset with a live instruction
        rst = 1'b0;
        InstrD = 32'h00500093; PCD = 32'h100; PCPlus4D = 32'h104;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", zero_e);
        @(negedge clk);
        rst = 1'b1;

        step("addi", 32'h00500093, 32'h100, 1'b0, 5'd0, 32'd0);
        chk("addi_imm", ImmExtE, 32'd5);
        chk("addi_rd", {27'd0, RDE}, 32'd1);

        step("wb_x2", 32'h00000013, 32'h104, 1'b1, 5'd2, 32'hDEADBEEF);
        step("add_x2", 32'h00210233, 32'h108, 1'b0, 5'd0, 32'd0);
        chk("add_rd1", RD1E, 32'hDEADBEEF);
        chk("add_rd2", RD2E, 32'hDEADBEEF);

        step("wb_x0", 32'h00000013, 32'h10C, 1'b1, 5'd0, 32'h1234);
        step("rd_x0", 32'h00000033, 32'h110, 1'b0, 5'd0, 32'd0);
        chk("x0_rd1", RD1E, 32'd0);

        step("sw", 32'hFE112E23, 32'h114, 1'b0, 5'd0, 32'd0);
        chk("sw_imm", ImmExtE, 32'hFFFFFFFC);
        step("beq", 32'hFE000EE3, 32'h118, 1'b0, 5'd0, 32'd0);
        chk("beq_imm", ImmExtE, 32'hFFFFFFFC);
        step("jal", 32'h0080006F, 32'h11C, 1'b0, 5'd0, 32'd0);
        chk("jal_imm", ImmExtE, 32'd8);

        // Same-cycle write/read of x3
        step("hazard", 32'h000182B3, 32'h120, 1'b1, 5'd3, 32'd7);
`ifdef DECODE_WB_BYPASS_EN
        chk("hazard_rd1", RD1E, 32'd7);
`else
        chk("hazard_rd1", RD1E, 32'd0);
`endif
        step("hazard_next", 32'h000182B3, 32'h124, 1'b0, 5'd0, 32'd0);
        chk("hazard_next_rd1", RD1E, 32'd7);

        step("illegal", 32'hFFFFFFFF, 32'h200, 1'b0, 5'd0, 32'd0);
        chk("illegal_pc", PCE, 32'h200);
        chk("illegal_imm", ImmExtE, 32'd0);

        step("sub", 32'h40208233, 32'h204, 1'b0, 5'd0, 32'd0);
        chk("sub_alu", {29'd0, ALUControlE}, 32'd1);

        // Randomised mix with writebacks
        for (int n = 0; n < 60; n++) begin
            r = $urandom();
            step("rand", {r[31:7], ops[$urandom_range(0, 6)]}, $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all("async_reset", zero_e);
        for (int k = 0; k < 32; k++) mregs[k] = '0;
        @(negedge clk);
        rst = 1'b1;
        step("post_reset", 32'h00210233, 32'h300, 1'b0, 5'd0, 32'd0);
        chk("post_reset_rd1", RD1E, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage (ID) of the 5-stage RV32I pipeline; consumes the IF/ID bundle (InstrD, PCD, PCPlus4D) driven by the fetch stage.
- Decodes the instruction, reads the 32x32 register file and sign-extends the immediate.
- Accepts writeback from the W stage and registers everything into the ID/EX pipeline register for the execute stage.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, number of architectural registers; x0 hard-wired to zero

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- InstrD  input  32  instruction from IF/ID
- PCD  input  32  PC of InstrD
- PCPlus4D  input  32  PCD+4
- RegWriteW  input  1  writeback enable
- RDW  input  5  writeback destination register
- ResultW  input  32  writeback data
- RegWriteE  output  1  register-write control to EX
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  output  1  store enable
- JumpE  output  1  jal
- BranchE  output  1  beq
- ALUSrcE  output  1  0 = RD2, 1 = immediate
- ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E  output  32  rs1 data
- RD2E  output  32  rs2 data
- ImmExtE  output  32  sign-extended immediate
- Rs1E  output  5  InstrD[19:15]
- Rs2E  output  5  InstrD[24:20]
- RDE  output  5  InstrD[11:7]
- PCE  output  32  registered PCD
- PCPlus4E  output  32  registered PCPlus4D

Behaviour:
- Reset: ID/EX register and all 32 registers clear to 0 asynchronously while rst=0. Every output is gated to 0 while rst=0 (output = rst ? reg : 0).
- Latency: all E outputs reflect the InstrD/PCD presented one rising edge earlier. No stall or flush.
- Main decoder, by opcode InstrD[6:0]:
  - 0000011 lw: RegWrite=1, ImmSrc=I, ALUSrc=1, ResultSrc=01, ALUOp=00
  - 0100011 sw: MemWrite=1, ImmSrc=S, ALUSrc=1, ALUOp=00
  - 0110011 R-type: RegWrite=1, ALUOp=10
  - 0010011 I-ALU: RegWrite=1, ImmSrc=I, ALUSrc=1, ALUOp=10
  - 1100011 beq: Branch=1, ImmSrc=B, ALUOp=01
  - 1101111 jal: RegWrite=1, Jump=1, ImmSrc=J, ResultSrc=10
  - Any other opcode: all controls 0, ImmExt 0 (behaves as bubble).
- ALU decoder:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000: sub only when funct7[5] & op[5] both 1, else add
    - 010: slt
    - 110: or
    - 111: and
    - other funct3: add
- Immediate extension (sign bit always InstrD[31]):
  - I: {20{i31}, i[31:20]}
  - S: {20{i31}, i[31:25], i[11:7]}
  - B: {19{i31}, i31, i7, i[30:25], i[11:8], 0}
  - J: {11{i31}, i31, i[19:12], i20, i[30:21], 0}
- Register file:
  - Two combinational read ports, addressed by Rs1/Rs2 of InstrD.
  - Write happens on the rising edge when RegWriteW=1 and RDW!=0.
  - Writes to x0 are ignored; x0 always reads 0.
- Simultaneous write and read of the same register in one cycle: result depends on the optional feature below.
- Reset mid-operation: contents are lost and outputs drop to 0 immediately. The first instruction after rst rises is decoded normally.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: read ports are write-through. If RegWriteW=1, RDW!=0 and RDW equals the read address, the read port returns ResultW in the same cycle.
- Not defined: the read returns the pre-write value. The hazard unit must cover this case by forwarding.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUControl codes
  - ImmSrc encoding (I=00, S=01, B=10, J=11)
  - ResultSrc encoding
  - XLEN
- One natural sub-module, register_file: 32x32, async clear, x0 hard zero, bypass under the macro. Decoder and immediate extender stay inline.

Test Plan:
- Reset: hold rst=0 with InstrD=0x00500093 -> all outputs 0. Release rst, one clock -> RegWriteE=1, ALUSrcE=1, ImmExtE=5, RDE=1.
- Writeback then read: RegWriteW=1, RDW=2, ResultW=0xDEADBEEF, clock. Then InstrD=0x00210233 (add x4,x2,x2) -> RD1E=RD2E=0xDEADBEEF, ALUControlE=000.
- x0 protection: write RDW=0, ResultW=0x1234. Then read x0 via InstrD=0x00000033 -> RD1E=0.
- Immediates:
  - sw 0xFE112E23 -> ImmExtE=0xFFFFFFFC, MemWriteE=1
  - beq 0xFE000EE3 -> ImmExtE=0xFFFFFFFC, BranchE=1
  - jal 0x0080006F -> ImmExtE=8, ResultSrcE=10
- Same-cycle hazard: RegWriteW=1, RDW=3, ResultW=7 while InstrD reads x3 (old value 0).
  - Bypass defined -> RD1E=7.
  - Bypass not defined -> RD1E=0.
  - In both builds, a second read of x3 in the following cycle returns 7.
- Illegal opcode 0xFFFFFFFF -> all E control outputs 0, ImmExtE=0; PCE/PCPlus4E still track the inputs.
